// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared definitions for the UART transmit path: frame
//                sequencer state encoding, TX output mux select codes and
//                small decode helpers used by the sequencer and output mux.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

  // Frame sequencer states (binary encoded; codes 5..7 are unused and
  // recover to idle on the next clock edge).
  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  // TX output mux select codes, shared with the registered output mux.
  localparam logic [1:0] MUX_SEL_START = 2'b00;
  localparam logic [1:0] MUX_SEL_STOP  = 2'b01;
  localparam logic [1:0] MUX_SEL_DATA  = 2'b10;
  localparam logic [1:0] MUX_SEL_PAR   = 2'b11;

  // Map a sequencer state onto the mux select it drives. Idle, stop and
  // any unused code all select the stop level so the line idles high.
  function automatic logic [1:0] f_mux_sel(input logic [2:0] st);
    logic [1:0] sel;
    sel = MUX_SEL_STOP;
    case (st)
      c_st_start:  sel = MUX_SEL_START;
      c_st_data:   sel = MUX_SEL_DATA;
      c_st_parity: sel = MUX_SEL_PAR;
      default:     sel = MUX_SEL_STOP;
    endcase
    return sel;
  endfunction

  // A frame is in progress only in the four legal framing states; an
  // unused code reads as not busy while it recovers.
  function automatic logic f_is_busy(input logic [2:0] st);
    logic b;
    b = 1'b0;
    case (st)
      c_st_start, c_st_data, c_st_parity, c_st_stop: b = 1'b1;
      default:                                        b = 1'b0;
    endcase
    return b;
  endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_parity_calc.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_parity_calc
//  Description : Combinational parity generator. par_typ=0 gives even
//                parity, par_typ=1 gives odd parity over DATA_WIDTH bits.
//                Shared between the TX sequencer and the RX parity checker.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // XOR chain seeded with the parity type so odd parity falls out directly.
  logic [DATA_WIDTH:0] w_chain;

  assign w_chain[0] = par_typ;

  // One XOR stage per payload bit.
  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_xor
      assign w_chain[i+1] = w_chain[i] ^ data[i];
    end
  endgenerate

  assign par_bit = w_chain[DATA_WIDTH];

endmodule : uart_tx_parity_calc
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fsm
//  Description : UART transmit frame sequencer. Accepts a parallel payload
//                and walks start / data (LSB first) / optional parity / stop,
//                driving the select and data inputs of the TX output mux.
//                One CLK cycle equals one bit period.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int              CNT_W      = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  w_accept;
  logic                  w_last_bit;

  // A new frame is taken only from idle or from the stop bit, which gives
  // back-to-back frames with no idle gap while requests mid-frame are dropped.
  assign w_accept   = DATA_VALID && ((r_state == c_st_idle) || (r_state == c_st_stop));
  assign w_last_bit = (r_bit_cnt == c_last_cnt);

  // Next-state decode; unused codes fall back to idle.
  always_comb begin
    w_state_nxt = c_st_idle;
    case (r_state)
      c_st_idle:   w_state_nxt = w_accept ? c_st_start : c_st_idle;
      c_st_start:  w_state_nxt = c_st_data;
      c_st_data: begin
        if (w_last_bit) begin
          w_state_nxt = r_par_en ? c_st_parity : c_st_stop;
        end else begin
          w_state_nxt = c_st_data;
        end
      end
      c_st_parity: w_state_nxt = c_st_stop;
      c_st_stop:   w_state_nxt = w_accept ? c_st_start : c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bit counter: advances through the payload in DATA and parks at zero
  // everywhere else, so it is already cleared when START hands over.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bit_cnt <= '0;
    end else if ((r_state == c_st_data) && !w_last_bit) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end else begin
      r_bit_cnt <= '0;
    end
  end

  // Frame latch: payload and parity controls are captured only on accept,
  // so upstream changes mid-frame cannot disturb the frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_accept) begin
      r_data    <= P_DATA;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end

  // Parity of the latched payload; stable for the whole frame.
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (r_data),
    .par_typ (r_par_typ),
    .par_bit (par_bit)
  );

  // Output decodes use registered state only; no input reaches them.
  always_comb begin
    mux_sel  = f_mux_sel(r_state);
    busy     = f_is_busy(r_state);
    ser_data = 1'b0;
    if (r_state == c_st_data) begin
      ser_data = r_data[r_bit_cnt];
    end
  end

endmodule : uart_tx_fsm
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fsm
//  Description : Directed self-checking bench for uart_tx_fsm.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_fsm #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one bit period; sample 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a frame for one accept edge, then drop the request.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
  endtask

  // Entered with the DUT in START; walks the whole frame checking every
  // cycle and leaves one edge past STOP. With disturb set, a request pulse
  // and flipped inputs are applied during DATA and must be ignored.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic exp_par,
                             input bit disturb, input string tag);
    int         len;
    logic [1:0] exp_mux;
    len = 10 + int'(pe);
    for (int c = 0; c < len; c++) begin
      if (c == 0)                exp_mux = 2'b00;
      else if (c <= 8)           exp_mux = 2'b10;
      else if (pe && (c == 9))   exp_mux = 2'b11;
      else                       exp_mux = 2'b01;
      check_eq($sformatf("%s mux c%0d", tag, c), 32'(mux_sel), 32'(exp_mux));
      check_eq($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      check_eq($sformatf("%s par c%0d", tag, c), 32'(par_bit), 32'(exp_par));
      if ((c >= 1) && (c <= 8)) begin
        check_eq($sformatf("%s ser b%0d", tag, c - 1), 32'(ser_data), 32'(d[c-1]));
      end
      if (disturb && (c == 3)) begin
        DATA_VALID = 1'b1;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~PAR_TYP;
      end
      if (disturb && (c == 4)) begin
        DATA_VALID = 1'b0;
      end
      tick();
    end
  endtask

  // Confirm the sequencer sits idle for a couple of cycles.
  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check_eq($sformatf("%s idle busy c%0d", tag, c), 32'(busy), 32'd0);
      check_eq($sformatf("%s idle mux c%0d", tag, c), 32'(mux_sel), 32'(2'b01));
      tick();
    end
  endtask

  initial begin
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    RST        = 1'b0;

    // Reset values.
    #3;
    check_eq("rst mux", 32'(mux_sel), 32'(2'b01));
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst ser", 32'(ser_data), 32'd0);
    check_eq("rst par", 32'(par_bit), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check_idle("post_rst", 3);

    // 0xA5, even parity: 4 ones -> parity 0, 11 busy cycles.
    start_frame(8'hA5, 1'b1, 1'b0);
    check_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
    check_idle("a5", 2);

    // 0x01: odd parity -> 0, even parity -> 1.
    start_frame(8'h01, 1'b1, 1'b1);
    check_frame(8'h01, 1'b1, 1'b0, 1'b0, "01odd");
    check_idle("01odd", 1);
    start_frame(8'h01, 1'b1, 1'b0);
    check_frame(8'h01, 1'b1, 1'b1, 1'b0, "01even");
    check_idle("01even", 1);

    // 0x3C without parity: 10 busy cycles, no parity select.
    start_frame(8'h3C, 1'b0, 1'b0);
    check_frame(8'h3C, 1'b0, 1'b0, 1'b0, "3c");
    check_idle("3c", 2);

    // 0x96 odd parity (4 ones -> 1); mid-frame request and input changes ignored.
    start_frame(8'h96, 1'b1, 1'b1);
    check_frame(8'h96, 1'b1, 1'b1, 1'b1, "dist");
    check_idle("dist", 2);

    // Back-to-back with DATA_VALID held: 0x55 then 0xAA, even parity (both 0).
    P_DATA     = 8'h55;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    tick();
    P_DATA = 8'hAA;
    check_frame(8'h55, 1'b1, 1'b0, 1'b0, "b2b1");
    DATA_VALID = 1'b0;
    check_frame(8'hAA, 1'b1, 1'b0, 1'b0, "b2b2");
    check_idle("b2b", 2);

    // Reset asserted mid-DATA: outputs return to reset values at once.
    start_frame(8'hA5, 1'b1, 1'b1);
    tick();
    tick();
    check_eq("mid mux pre", 32'(mux_sel), 32'(2'b10));
    check_eq("mid par pre", 32'(par_bit), 32'd1);
    RST = 1'b0;
    #1;
    check_eq("mid rst mux", 32'(mux_sel), 32'(2'b01));
    check_eq("mid rst busy", 32'(busy), 32'd0);
    check_eq("mid rst par", 32'(par_bit), 32'd0);
    check_eq("mid rst ser", 32'(ser_data), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    check_idle("mid rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_tx_fsm
`default_nettype wire
